out_change_serializer: RTL and testbench

Serial reporter placed directly downstream of the 8-bit counter/result stage (`out` bus). It watches the result bus every clock, captures each new value when it changes, buffers the captured values in a small FIFO, and transmits them on a single wire as UART-style frames. Result codes can then be observed off-chip without a parallel bus.

---
 rtl/out_change_serializer.sv | 157 +++++++++++++++
 tb/tb_out_change_serializer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/out_change_serializer.sv
// rtl/out_change_serializer.sv - captures result-bus changes into a FIFO and sends them as UART-style frames
module out_change_serializer #(
   parameter int DATA_W     = 8,
   parameter int DEPTH      = 4,
   parameter int BIT_CYCLES = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [DATA_W-1:0]        data_in,
   input  logic                     clear_ovf,
   output logic                     tx,
   output logic                     busy,
   output logic                     overflow,
   output logic [$clog2(DEPTH):0]   fifo_level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [LW-1:0] FULL     = LW'(DEPTH);
   localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t            state, state_nxt;
   logic [CW-1:0]     cyc, cyc_nxt;
   logic [IW-1:0]     idx, idx_nxt;
   logic [DATA_W-1:0] shreg, shreg_nxt;
   logic              tx_nxt;

   logic [DATA_W-1:0] last_val;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic              push_req, push, pop, drop;

   // A full FIFO still accepts a value when the serializer pops on the same edge.
   assign push_req = (data_in != last_val);
   assign push     = push_req && ((fifo_level != FULL) || pop);
   assign drop     = push_req && !push;
   assign busy     = (state != IDLE);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         last_val   <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
         overflow   <= 1'b0;
      end else begin
         if (push_req)
            last_val <= data_in;
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)
            fifo_level <= fifo_level + LW'(1);
         else if (pop && !push)
            fifo_level <= fifo_level - LW'(1);
         if (drop)
            overflow <= 1'b1;
         else if (clear_ovf)
            overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= data_in;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         cyc   <= '0;
         idx   <= '0;
         shreg <= '0;
         tx    <= 1'b1;
      end else begin
         state <= state_nxt;
         cyc   <= cyc_nxt;
         idx   <= idx_nxt;
         shreg <= shreg_nxt;
         tx    <= tx_nxt;
      end
   end

   // tx_nxt is the line level for the state being entered, so tx stays registered.
   always_comb begin
      state_nxt = state;
      cyc_nxt   = cyc;
      idx_nxt   = idx;
      shreg_nxt = shreg;
      tx_nxt    = tx;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            tx_nxt = 1'b1;
            if (fifo_level != '0) begin
               pop       = 1'b1;
               shreg_nxt = mem[rd_ptr];
               cyc_nxt   = '0;
               state_nxt = START;
               tx_nxt    = 1'b0;
            end
         end
         START: begin
            if (cyc == CYC_LAST) begin
               cyc_nxt   = '0;
               idx_nxt   = '0;
               state_nxt = DATA;
               tx_nxt    = shreg[0];
            end else begin
               cyc_nxt = cyc + CW'(1);
            end
         end
         DATA: begin
            if (cyc == CYC_LAST) begin
               cyc_nxt = '0;
               if (idx == IDX_LAST) begin
                  state_nxt = STOP;
                  tx_nxt    = 1'b1;
               end else begin
                  idx_nxt   = idx + IW'(1);
                  shreg_nxt = {1'b0, shreg[DATA_W-1:1]};
                  tx_nxt    = shreg[1];
               end
            end else begin
               cyc_nxt = cyc + CW'(1);
            end
         end
         STOP: begin
            if (cyc == CYC_LAST) begin
               cyc_nxt = '0;
               if (fifo_level != '0) begin
                  pop       = 1'b1;
                  shreg_nxt = mem[rd_ptr];
                  state_nxt = START;
                  tx_nxt    = 1'b0;
               end else begin
                  state_nxt = IDLE;
                  tx_nxt    = 1'b1;
               end
            end else begin
               cyc_nxt = cyc + CW'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            tx_nxt    = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_out_change_serializer.sv
// tb/tb_out_change_serializer.sv - self-checking bench for out_change_serializer
module tb_out_change_serializer;

   localparam int DW = 8;
   localparam int DP = 4;
   localparam int BC = 4;
   localparam int FL = (DW + 2) * BC;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [DW-1:0] data_in = '0;
   logic          clear_ovf = 1'b0;
   logic          tx, busy, overflow;
   logic [2:0]    fifo_level;

   out_change_serializer #(.DATA_W(DW), .DEPTH(DP), .BIT_CYCLES(BC)) dut (
      .clk(clk),
      .reset_n(reset_n),
      .data_in(data_in),
      .clear_ovf(clear_ovf),
      .tx(tx),
      .busy(busy),
      .overflow(overflow),
      .fifo_level(fifo_level)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [DW-1:0] sb[$];
   int mon_n = 0;
   logic [FL-1:0] cap_tx, cap_busy;

   typedef struct {
      logic [DW-1:0] d;
      logic          clr;
      logic          acc;
      logic [2:0]    lvl;
      logic          ovf;
      logic          bsy;
      logic          txv;
   } vec_t;
   vec_t tbl[12];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic step(input logic [DW-1:0] d, input logic c);
      @(negedge clk);
      data_in   = d;
      clear_ovf = c;
      @(posedge clk);
      #1;
   endtask

   task automatic check_frame();
      logic [FL-1:0] exp_v;
      logic [DW-1:0] b8;
      int b;
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL frame_unexpected actual=%0h expected=none", cap_tx);
      end else begin
         b8 = sb.pop_front();
         for (int t = 0; t < FL; t++) begin
            b = t / BC;
            if (b == 0)           exp_v[t] = 1'b0;
            else if (b == DW + 1) exp_v[t] = 1'b1;
            else                  exp_v[t] = b8[b-1];
         end
         chk($sformatf("frame_tx_%0h", b8), cap_tx, exp_v);
         chk($sformatf("frame_busy_%0h", b8), cap_busy, {FL{1'b1}});
      end
   endtask

   task automatic wait_done(input string name, input int limit);
      int n = 0;
      while ((sb.size() != 0 || mon_n != 0) && n < limit) begin
         step(data_in, 1'b0);
         n++;
      end
      chk(name, (sb.size() == 0 && mon_n == 0), 1);
   endtask

   // Frame receiver: a low line while idle starts a FL-sample capture.
   initial forever begin
      @(posedge clk);
      #1;
      if (!reset_n) begin
         mon_n = 0;
      end else if (mon_n > 0 || tx === 1'b0) begin
         cap_tx[mon_n]   = tx;
         cap_busy[mon_n] = busy;
         mon_n++;
         if (mon_n == FL) begin
            check_frame();
            mon_n = 0;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      int bad;
      tbl[0]  = '{8'h01, 1'b0, 1'b1, 3'd1, 1'b0, 1'b0, 1'b1};
      tbl[1]  = '{8'h02, 1'b0, 1'b1, 3'd1, 1'b0, 1'b1, 1'b0};
      tbl[2]  = '{8'h03, 1'b0, 1'b1, 3'd2, 1'b0, 1'b1, 1'b0};
      tbl[3]  = '{8'h04, 1'b0, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0};
      tbl[4]  = '{8'h05, 1'b0, 1'b1, 3'd4, 1'b0, 1'b1, 1'b0};
      tbl[5]  = '{8'h06, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 1'b1};
      tbl[6]  = '{8'h06, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 1'b1};
      tbl[7]  = '{8'h06, 1'b1, 1'b0, 3'd4, 1'b0, 1'b1, 1'b1};
      tbl[8]  = '{8'h06, 1'b0, 1'b0, 3'd4, 1'b0, 1'b1, 1'b1};
      tbl[9]  = '{8'h07, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0};
      tbl[10] = '{8'h08, 1'b1, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0};
      tbl[11] = '{8'h08, 1'b0, 1'b0, 3'd4, 1'b1, 1'b1, 1'b0};

      repeat (2) @(posedge clk);
      #1;
      chk("reset_tx", tx, 1);
      chk("reset_busy", busy, 0);
      chk("reset_ovf", overflow, 0);
      chk("reset_level", fifo_level, 0);
      @(negedge clk);
      reset_n = 1'b1;

      bad = 0;
      for (int i = 0; i < 100; i++) begin
         step(8'h00, 1'b0);
         if (tx !== 1'b1 || busy !== 1'b0 || fifo_level !== 3'd0) bad++;
      end
      chk("nochange_bad_cycles", bad, 0);

      sb.push_back(8'h05);
      step(8'h05, 1'b0);
      chk("single_k_level", fifo_level, 1);
      chk("single_k_tx", tx, 1);
      chk("single_k_busy", busy, 0);
      step(8'h05, 1'b0);
      chk("single_k1_tx", tx, 0);
      chk("single_k1_busy", busy, 1);
      chk("single_k1_level", fifo_level, 0);
      repeat (39) step(8'h05, 1'b0);
      chk("single_last_busy", busy, 1);
      step(8'h05, 1'b0);
      chk("single_end_busy", busy, 0);
      chk("single_end_tx", tx, 1);
      chk("single_frames_done", (sb.size() == 0 && mon_n == 0), 1);

      for (int i = 0; i < 12; i++) begin
         if (tbl[i].acc) sb.push_back(tbl[i].d);
         step(tbl[i].d, tbl[i].clr);
         chk($sformatf("burst%0d_level", i), fifo_level, tbl[i].lvl);
         chk($sformatf("burst%0d_ovf", i), overflow, tbl[i].ovf);
         chk($sformatf("burst%0d_busy", i), busy, tbl[i].bsy);
         chk($sformatf("burst%0d_tx", i), tx, tbl[i].txv);
      end
      for (int i = 0; i < 29; i++) step(8'h08, i == 0);
      chk("pp_pre_level", fifo_level, 4);
      chk("pp_pre_ovf", overflow, 0);
      sb.push_back(8'h20);
      step(8'h20, 1'b0);
      chk("pp_level", fifo_level, 4);
      chk("pp_ovf", overflow, 0);
      chk("pp_busy", busy, 1);
      chk("pp_tx", tx, 0);
      wait_done("burst_frames_timeout", 400);
      step(8'h20, 1'b0);
      chk("burst_end_busy", busy, 0);
      chk("burst_end_level", fifo_level, 0);

      step(8'h81, 1'b0);
      repeat (10) step(8'h81, 1'b0);
      chk("midrst_pre_tx", tx, 0);
      chk("midrst_pre_busy", busy, 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("midrst_tx", tx, 1);
      chk("midrst_busy", busy, 0);
      chk("midrst_level", fifo_level, 0);
      chk("midrst_ovf", overflow, 0);
      sb.delete();
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      sb.push_back(8'h81);
      wait_done("midrst_frame_timeout", 100);
      step(8'h81, 1'b0);
      chk("midrst_end_busy", busy, 0);
      chk("midrst_end_tx", tx, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
